// File: rtl/rank_stream_tx.sv
// rank_stream_tx: stores per-node rank values and streams them as 4-lane packed words
// (value, node ID, valid), N/4 beats per frame, and raises done after ITERS frames.
// Optional double-buffered rank storage with the RANK_PINGPONG_EN macro.
module rank_stream_tx #(
  parameter int WIDTH = 31,
  parameter int N     = 64,
  parameter int ITERS = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [5:0]       wr_addr,
  input  logic [WIDTH-8:0] wr_data,
  input  logic             start,
  output logic [WIDTH-1:0] unsort_00,
  output logic [WIDTH-1:0] unsort_01,
  output logic [WIDTH-1:0] unsort_10,
  output logic [WIDTH-1:0] unsort_11,
  output logic             busy,
  output logic [5:0]       frame_cnt,
  output logic             done,
  output logic             wr_drop
);

  localparam int VW = WIDTH - 7;
  localparam int BW = (N > 4) ? $clog2(N / 4) : 1;
  localparam int AW = BW + 2;
  localparam logic [BW-1:0] LAST = BW'(N / 4 - 1);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t            state;
  logic [BW-1:0]     b;
  logic [BW-1:0]     rd_beat;
  logic [WIDTH-1:0]  lane_q   [4];
  logic [WIDTH-1:0]  lane_nxt [4];
  logic [AW-1:0]     lane_idx [4];
  logic [VW-1:0]     lane_val [4];
  logic              in_range;
  logic              wr_ok;
  logic              start_ok;

  // Node IDs above N-1 are silently ignored; with N=64 every 6-bit ID is legal.
  if (N >= 64) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (wr_addr < 6'(N));
  end

  assign start_ok = (state == IDLE) && start && !done;

`ifdef RANK_PINGPONG_EN
  logic [VW-1:0] mem [2][N];
  logic          wbank;
  logic          rd_bank;

  // Writes always land in the write bank, even while a frame is streaming.
  assign wr_ok   = wr_en && in_range;
  // During SEND the frame reads the bank that was swapped out at start.
  assign rd_bank = (state == SEND) ? ~wbank : wbank;
  assign wr_drop = 1'b0;

  // Rank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wbank][wr_addr[AW-1:0]] <= wr_data;
  end

  // An accepted start hands the freshly written bank to the transmitter.
  always_ff @(posedge clk) begin
    if (reset)         wbank <= 1'b0;
    else if (start_ok) wbank <= ~wbank;
  end
`else
  logic [VW-1:0] mem [N];

  // Single bank: writes during a frame would corrupt it, so they are dropped.
  assign wr_ok = wr_en && in_range && !busy;

  // Rank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[AW-1:0]] <= wr_data;
  end

  // Sticky flag for any write discarded while busy.
  always_ff @(posedge clk) begin
    if (reset)              wr_drop <= 1'b0;
    else if (wr_en && busy) wr_drop <= 1'b1;
  end
`endif

  // Assemble the next beat; a same-cycle write bypasses into beat 0 at start.
  always_comb begin
    rd_beat = (state == SEND) ? b + 1'b1 : '0;
    for (int k = 0; k < 4; k++) begin
      lane_idx[k] = {rd_beat, k[1:0]};
`ifdef RANK_PINGPONG_EN
      lane_val[k] = mem[rd_bank][lane_idx[k]];
`else
      lane_val[k] = mem[lane_idx[k]];
`endif
      if (wr_ok && (state != SEND) && (wr_addr[AW-1:0] == lane_idx[k]))
        lane_val[k] = wr_data;
      lane_nxt[k] = {lane_val[k], 6'(lane_idx[k]), 1'b1};
    end
  end

  // Frame FSM with registered lane words, busy, frame count and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      b         <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      done      <= 1'b0;
      for (int k = 0; k < 4; k++) lane_q[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= SEND;
            b     <= '0;
            busy  <= 1'b1;
            for (int k = 0; k < 4; k++) lane_q[k] <= lane_nxt[k];
          end
        end
        SEND: begin
          if (b == LAST) begin
            state <= FIN;
            busy  <= 1'b0;
            if (frame_cnt != 6'(ITERS)) frame_cnt <= frame_cnt + 1'b1;
            for (int k = 0; k < 4; k++) lane_q[k] <= '0;
          end else begin
            b <= b + 1'b1;
            for (int k = 0; k < 4; k++) lane_q[k] <= lane_nxt[k];
          end
        end
        FIN: begin
          if (frame_cnt == 6'(ITERS)) done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign unsort_00 = lane_q[0];
  assign unsort_01 = lane_q[1];
  assign unsort_10 = lane_q[2];
  assign unsort_11 = lane_q[3];

endmodule
